eth_backoff_ctrl: RTL and testbench
===================================

# eth_backoff_ctrl

Half-duplex Ethernet transmit scheduler implementing truncated binary exponential backoff (CSMA/CD). It sits between the MAC transmit path and the PHY-side collision detect, and gates when the MAC may start a transmit attempt. It contains a free-running 16-bit LFSR that is sampled on each collision to pick the backoff slot count. It aborts the frame after an excessive number of collisions.

## Interface
- SLOT_CYCLES, 64: clock cycles per slot time; must be ≥ 2.
- BACKOFF_LIMIT, 10: maximum backoff exponent k; range 1..10.
- ATTEMPT_LIMIT, 16: collision count at which the frame is aborted; range 2..31.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tx_req  in  1  level; MAC has a frame pending
- collision  in  1  1-cycle pulse; collision on the current attempt
- tx_done  in  1  1-cycle pulse; current attempt completed without collision
- tx_grant  out  1  level; MAC may start or continue an attempt
- backoff_active  out  1  level; high while in BACKOFF
- abort  out  1  1-cycle pulse; frame dropped after excessive collisions
- attempt_cnt  out  5  collisions seen for the current frame
- slots_remaining  out  10  backoff slots still to wait

## Operation
- **LFSR**
  - 16 bits, loaded with SEED while rst_n is low.
  - Every other cycle it shifts right: next = {fb, q[15:1]}, with fb = q[0]^q[2]^q[3]^q[5].
  - It runs continuously in all states.
- **States:** IDLE, READY, BACKOFF, ABORT. All registers are cleared or held by the asynchronous reset.
- **IDLE**
  - tx_grant=0, attempt_cnt=0.
  - tx_req=1 → READY.
- **READY**
  - tx_grant=1.
  - collision:
    - Form n = attempt_cnt+1.
    - If n == ATTEMPT_LIMIT → ABORT.
    - Otherwise: attempt_cnt ← n, k = min(n, BACKOFF_LIMIT), slots_remaining ← lfsr[k-1:0] (zero-extended; uses the LFSR value in the collision cycle), slot timer ← SLOT_CYCLES-1, → BACKOFF.
  - tx_done (without collision) → IDLE, attempt_cnt ← 0.
  - tx_req=0 (no collision, no tx_done) → IDLE, attempt_cnt ← 0.
- **BACKOFF**
  - tx_grant=0, backoff_active=1.
  - If slots_remaining == 0 → READY.
  - Otherwise:
    - Timer == 0: slots_remaining decrements and the timer reloads to SLOT_CYCLES-1.
    - Timer != 0: the timer decrements.
  - tx_req=0 → IDLE (attempt_cnt ← 0, slots_remaining ← 0). This takes priority over counting.
- **ABORT**
  - abort=1 for exactly this one cycle; tx_grant=0.
  - attempt_cnt holds ATTEMPT_LIMIT-1 during this cycle.
  - Next state is IDLE and attempt_cnt ← 0, regardless of tx_req.
  - If tx_req is still high, a new frame starts from IDLE on the following cycle.
- **Priorities and ignored inputs**
  - collision and tx_done in the same READY cycle: collision wins.
  - collision and tx_done outside READY: ignored.
- **Widths:** slot timer is clog2(SLOT_CYCLES) bits; slots_remaining max 2^BACKOFF_LIMIT-1. No counter wraps.

## Timing
- **Reset values:** tx_grant=0, backoff_active=0, abort=0, attempt_cnt=0, slots_remaining=0, state IDLE, LFSR=SEED.
- All outputs are registered (state-decoded from registers), so there is no combinational input→output path.
- tx_req rising in IDLE → tx_grant=1 on the next cycle.
- collision in cycle t (READY):
  - tx_grant=0 and backoff_active=1 from t+1.
  - Time in BACKOFF is r·SLOT_CYCLES+1 cycles (r = sampled slot count).
  - tx_grant returns at t+2+r·SLOT_CYCLES.
- r=0: exactly one BACKOFF cycle; tx_grant low for one cycle.
- tx_done in cycle t → tx_grant=0 at t+1 (IDLE). If tx_req is still high, READY again at t+2.
- Asynchronous reset mid-BACKOFF or mid-ABORT: immediate return to reset values; no abort pulse is emitted.

## Test plan
- **Reset:** hold rst_n=0 with tx_req=1 and collision pulses → all outputs 0 and state IDLE throughout. After release, tx_grant=1 one cycle later.
- **Clean send:** tx_req=1, tx_done pulse 10 cycles after grant → tx_grant=0 next cycle, attempt_cnt=0, abort never asserts.
- **Single collision** (SLOT_CYCLES=64):
  - attempt_cnt=1, and slots_remaining = lfsr[0] per the bit-accurate LFSR model.
  - tx_grant low for exactly 64·r+1 cycles.
  - Repeat with seed 16'h0002 so that r=0 → exactly 1 cycle low.
- **Exponent truncation** (BACKOFF_LIMIT=3, ATTEMPT_LIMIT=16):
  - On collisions 4..15, sampled r ≤ 7 and matches lfsr[2:0] from the model.
  - attempt_cnt increments 1..15.
- **Excessive collisions:**
  - Issue 16 collisions, each as soon as grant returns.
  - abort is a single 1-cycle pulse after the 16th, with attempt_cnt=15 during the pulse.
  - Then IDLE → READY with attempt_cnt=0 while tx_req stays high.
- **Cancel and simultaneous events:**
  - Drop tx_req mid-BACKOFF → IDLE next cycle, slots_remaining=0, attempt_cnt=0.
  - collision and tx_done in the same cycle → treated as a collision (attempt_cnt=1, BACKOFF).

Source files
------------

// File: rtl/eth_backoff_ctrl.sv
// Half-duplex Ethernet transmit scheduler: truncated binary exponential
// backoff after collisions, with frame abort on excessive collisions.
module eth_backoff_ctrl #(
  parameter int unsigned SLOT_CYCLES   = 64,
  parameter int unsigned BACKOFF_LIMIT = 10,
  parameter int unsigned ATTEMPT_LIMIT = 16,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_req,
  input  logic       collision,
  input  logic       tx_done,
  output logic       tx_grant,
  output logic       backoff_active,
  output logic       abort,
  output logic [4:0] attempt_cnt,
  output logic [9:0] slots_remaining
);

  localparam int unsigned         TIMER_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]  TIMER_RELOAD = TIMER_W'(SLOT_CYCLES - 1);
  localparam logic [4:0]          ATTEMPT_MAX  = 5'(ATTEMPT_LIMIT);
  localparam logic [4:0]          K_LIMIT      = 5'(BACKOFF_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READY,
    ST_BACKOFF,
    ST_ABORT
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [15:0]          lfsr;
  logic                 lfsr_phase;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_nx;
  logic [4:0]           attempt_nx;
  logic [9:0]           slots_nx;
  logic [4:0]           attempt_inc;
  logic [3:0]           k;
  logic [9:0]           slot_mask;

  // Free-running LFSR; advances on every second clock, first shift on the
  // second edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= SEED;
      lfsr_phase <= 1'b0;
    end else begin
      lfsr_phase <= ~lfsr_phase;
      if (lfsr_phase) begin
        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
    end
  end

  // Next-state, counter and backoff-window logic.
  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    attempt_nx  = attempt_cnt;
    slots_nx    = slots_remaining;
    attempt_inc = attempt_cnt + 5'd1;
    k           = (attempt_inc > K_LIMIT) ? K_LIMIT[3:0] : attempt_inc[3:0];
    slot_mask   = 10'((11'd1 << k) - 11'd1);

    case (state)
      ST_IDLE: begin
        attempt_nx = 5'd0;
        slots_nx   = 10'd0;
        if (tx_req) begin
          state_nx = ST_READY;
        end
      end

      ST_READY: begin
        // Collision wins over tx_done and over a dropped request.
        if (collision) begin
          if (attempt_inc == ATTEMPT_MAX) begin
            state_nx = ST_ABORT;
          end else begin
            attempt_nx = attempt_inc;
            slots_nx   = lfsr[9:0] & slot_mask;
            timer_nx   = TIMER_RELOAD;
            state_nx   = ST_BACKOFF;
          end
        end else if (tx_done || !tx_req) begin
          attempt_nx = 5'd0;
          state_nx   = ST_IDLE;
        end
      end

      ST_BACKOFF: begin
        if (!tx_req) begin
          attempt_nx = 5'd0;
          slots_nx   = 10'd0;
          state_nx   = ST_IDLE;
        end else if (slots_remaining == 10'd0) begin
          state_nx = ST_READY;
        end else if (timer == '0) begin
          slots_nx = slots_remaining - 10'd1;
          timer_nx = TIMER_RELOAD;
        end else begin
          timer_nx = timer - TIMER_W'(1);
        end
      end

      ST_ABORT: begin
        attempt_nx = 5'd0;
        state_nx   = ST_IDLE;
      end

      default: begin
        attempt_nx = 5'd0;
        slots_nx   = 10'd0;
        state_nx   = ST_IDLE;
      end
    endcase
  end

  // State, counters and state-decoded outputs, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      timer           <= '0;
      attempt_cnt     <= 5'd0;
      slots_remaining <= 10'd0;
      tx_grant        <= 1'b0;
      backoff_active  <= 1'b0;
      abort           <= 1'b0;
    end else begin
      state           <= state_nx;
      timer           <= timer_nx;
      attempt_cnt     <= attempt_nx;
      slots_remaining <= slots_nx;
      tx_grant        <= (state_nx == ST_READY);
      backoff_active  <= (state_nx == ST_BACKOFF);
      abort           <= (state_nx == ST_ABORT);
    end
  end

endmodule

// File: tb/tb_eth_backoff_ctrl.sv
// Self-checking bench for eth_backoff_ctrl: reference LFSR model plus a
// scoreboard of expected backoff outcomes per collision.
module tb_eth_backoff_ctrl;

  localparam int unsigned SLOT    = 64;
  localparam int unsigned BL_A    = 3;
  localparam int unsigned BL_B    = 10;
  localparam int unsigned LIMIT   = 16;
  localparam logic [15:0] SEED_A  = 16'hACE1;
  localparam logic [15:0] SEED_B  = 16'h0002;
  localparam int unsigned WAIT_MAX = 8000;

  typedef struct {
    int unsigned attempt;
    int unsigned slots;
    int unsigned low;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_req, collision, tx_done;
  logic       tx_grant, backoff_active, abort;
  logic [4:0] attempt_cnt;
  logic [9:0] slots_remaining;
  logic       req2, col2, done2;
  logic       grant2, ba2, abort2;
  logic [4:0] ac2;
  logic [9:0] sr2;

  logic [15:0] m_lfsr_a, m_lfsr_b;
  logic        m_phase;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned abort_seen = 0;
  exp_t        sb[$];

  eth_backoff_ctrl #(
    .SLOT_CYCLES(SLOT), .BACKOFF_LIMIT(BL_A), .ATTEMPT_LIMIT(LIMIT), .SEED(SEED_A)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .collision(collision), .tx_done(tx_done),
    .tx_grant(tx_grant), .backoff_active(backoff_active), .abort(abort),
    .attempt_cnt(attempt_cnt), .slots_remaining(slots_remaining)
  );

  eth_backoff_ctrl #(
    .SLOT_CYCLES(SLOT), .BACKOFF_LIMIT(BL_B), .ATTEMPT_LIMIT(LIMIT), .SEED(SEED_B)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_req(req2), .collision(col2), .tx_done(done2),
    .tx_grant(grant2), .backoff_active(ba2), .abort(abort2),
    .attempt_cnt(ac2), .slots_remaining(sr2)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
  endfunction

  // Reference LFSRs: shift on every second edge after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr_a <= SEED_A;
      m_lfsr_b <= SEED_B;
      m_phase  <= 1'b0;
    end else begin
      m_phase <= ~m_phase;
      if (m_phase) begin
        m_lfsr_a <= lfsr_step(m_lfsr_a);
        m_lfsr_b <= lfsr_step(m_lfsr_b);
      end
    end
  end

  function automatic int unsigned calc_r(input logic [15:0] l, input int unsigned n,
                                         input int unsigned bl);
    int unsigned kk;
    logic [9:0]  m;
    kk = (n < bl) ? n : bl;
    m  = 10'((32'd1 << kk) - 32'd1);
    return 32'(l[9:0] & m);
  endfunction

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; every observed cycle is screened for abort.
  task automatic tick();
    @(negedge clk);
    if (abort) abort_seen++;
  endtask

  // Count cycles with grant low (starting from the current one) until it returns.
  task automatic wait_grant(input bit sel, output int unsigned low);
    low = 1;
    for (int i = 0; i < WAIT_MAX; i++) begin
      tick();
      if (sel ? grant2 : tx_grant) break;
      low++;
    end
  endtask

  // Issue one collision from READY, score it, and wait for the grant to return.
  task automatic issue_collision(input bit sel, input int unsigned n);
    exp_t        e;
    int unsigned low;
    e.attempt = n;
    e.slots   = sel ? calc_r(m_lfsr_b, n, BL_B) : calc_r(m_lfsr_a, n, BL_A);
    e.low     = e.slots * SLOT + 1;
    sb.push_back(e);
    if (sel) col2 = 1'b1; else collision = 1'b1;
    tick();
    col2 = 1'b0;
    collision = 1'b0;
    e = sb.pop_front();
    check_eq("coll_attempt", sel ? 32'(ac2) : 32'(attempt_cnt), e.attempt);
    check_eq("coll_slots", sel ? 32'(sr2) : 32'(slots_remaining), e.slots);
    check_eq("coll_backoff_active", sel ? 32'(ba2) : 32'(backoff_active), 1);
    check_eq("coll_grant_low", sel ? 32'(grant2) : 32'(tx_grant), 0);
    if (!sel && n >= 4) check_eq("trunc_range", 32'(slots_remaining <= 10'd7), 1);
    wait_grant(sel, low);
    check_eq("coll_low_cycles", low, e.low);
  endtask

  initial begin
    int unsigned low;
    rst_n = 1'b0;
    tx_req = 1'b1; collision = 1'b0; tx_done = 1'b0;
    req2 = 1'b1; col2 = 1'b0; done2 = 1'b0;

    // Reset held with requests and collision pulses.
    for (int i = 0; i < 4; i++) begin
      collision = i[0];
      col2      = i[0];
      tick();
      check_eq("reset_outs_a", 32'({tx_grant, backoff_active, abort, attempt_cnt, slots_remaining}), 0);
      check_eq("reset_outs_b", 32'({grant2, ba2, abort2, ac2, sr2}), 0);
    end
    collision = 1'b0;
    col2 = 1'b0;
    rst_n = 1'b1;
    tick();
    check_eq("post_reset_grant_a", 32'(tx_grant), 1);
    check_eq("post_reset_grant_b", 32'(grant2), 1);

    // Seed 0x0002 colliding on the first grant cycle samples r=0.
    issue_collision(1'b1, 1);
    req2 = 1'b0;
    tick();
    check_eq("b_idle_grant", 32'(grant2), 0);

    // Clean send.
    repeat (10) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_eq("done_grant", 32'(tx_grant), 0);
    check_eq("done_attempt", 32'(attempt_cnt), 0);
    tick();
    check_eq("done_regrant", 32'(tx_grant), 1);
    check_eq("done_no_abort", abort_seen, 0);

    // Collisions 1..15 back to back, then the aborting 16th.
    for (int n = 1; n < 16; n++) issue_collision(1'b0, 32'(n));
    collision = 1'b1;
    tick();
    collision = 1'b0;
    check_eq("abort_pulse", 32'(abort), 1);
    check_eq("abort_attempt", 32'(attempt_cnt), LIMIT - 1);
    check_eq("abort_grant", 32'(tx_grant), 0);
    tick();
    check_eq("abort_end", 32'(abort), 0);
    check_eq("abort_idle_attempt", 32'(attempt_cnt), 0);
    check_eq("abort_idle_grant", 32'(tx_grant), 0);
    tick();
    check_eq("abort_regrant", 32'(tx_grant), 1);
    check_eq("abort_count", abort_seen, 1);

    // Cancel mid-backoff: collide when the model guarantees r=1.
    for (int i = 0; i < 64; i++) begin
      if (m_lfsr_a[0]) break;
      tick();
    end
    collision = 1'b1;
    tick();
    collision = 1'b0;
    check_eq("cancel_slots", 32'(slots_remaining), 1);
    check_eq("cancel_in_backoff", 32'(backoff_active), 1);
    repeat (5) tick();
    tx_req = 1'b0;
    tick();
    check_eq("cancel_backoff_off", 32'(backoff_active), 0);
    check_eq("cancel_slots_clr", 32'(slots_remaining), 0);
    check_eq("cancel_attempt_clr", 32'(attempt_cnt), 0);
    check_eq("cancel_grant", 32'(tx_grant), 0);
    tx_req = 1'b1;
    tick();
    check_eq("cancel_regrant", 32'(tx_grant), 1);

    // Collision and tx_done together.
    collision = 1'b1;
    tx_done   = 1'b1;
    tick();
    collision = 1'b0;
    tx_done   = 1'b0;
    check_eq("simul_attempt", 32'(attempt_cnt), 1);
    check_eq("simul_backoff", 32'(backoff_active), 1);
    check_eq("simul_grant", 32'(tx_grant), 0);
    tx_req = 1'b0;
    tick();
    check_eq("simul_cancel_attempt", 32'(attempt_cnt), 0);
    check_eq("final_abort_count", abort_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
